vregfile_wbqueue: RTL and testbench

//  Write-back queue sitting directly upstream of the vector register file's single write port (c_reg/c_writedatain/c_we).

---
 rtl/vregfile_wbqueue_pkg.sv | 19 +
 rtl/vregfile_wbq_fifo.sv | 73 +++++++
 rtl/vregfile_wbqueue.sv | 84 ++++++++
 tb/tb_vregfile_wbqueue.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/vregfile_wbqueue_pkg.sv
// Shared write-back definitions: default geometry, producer IDs and the queued entry layout.
// Also used by the lane write-back muxes that feed producer 0.
package vregfile_wbqueue_pkg;

  localparam int WBQ_WIDTH       = 32;
  localparam int WBQ_NUMREGS     = 16;
  localparam int WBQ_LOG2NUMREGS = 4;
  localparam int WBQ_DEPTH       = 4;
  localparam int WBQ_LOG2DEPTH   = 2;

  localparam logic WBQ_P0 = 1'b0;
  localparam logic WBQ_P1 = 1'b1;

  typedef struct packed {
    logic [WBQ_LOG2NUMREGS-1:0] dst;
    logic [WBQ_WIDTH-1:0]       data;
  } wbq_entry_t;

endpackage

// File: rtl/vregfile_wbq_fifo.sv
// In-order write-back storage: circular buffer with pointers and occupancy count.
// VREGFILE_WBQ_BYPASS_EN adds a youngest-match tag search over occupied entries.
module vregfile_wbq_fifo
  import vregfile_wbqueue_pkg::*;
#(
  parameter int WIDTH       = WBQ_WIDTH,
  parameter int LOG2NUMREGS = WBQ_LOG2NUMREGS,
  parameter int DEPTH       = WBQ_DEPTH,
  parameter int LOG2DEPTH   = WBQ_LOG2DEPTH
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   push,
  input  logic [LOG2NUMREGS-1:0] push_reg,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [LOG2NUMREGS-1:0] head_reg,
  output logic [WIDTH-1:0]       head_data,
`ifdef VREGFILE_WBQ_BYPASS_EN
  input  logic [LOG2NUMREGS-1:0] rd_reg,
  output logic                   rd_hit,
  output logic [WIDTH-1:0]       rd_data,
`endif
  output logic [LOG2DEPTH:0]     count
);

  logic [LOG2NUMREGS-1:0] tag_q  [DEPTH];
  logic [WIDTH-1:0]       data_q [DEPTH];
  logic [LOG2DEPTH-1:0]   rd_ptr, wr_ptr;
  logic [LOG2DEPTH:0]     count_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count_q <= count_q + {{LOG2DEPTH{1'b0}}, push} - {{LOG2DEPTH{1'b0}}, pop};
    end
  end

  // Storage carries no reset; occupancy alone decides what is live.
  always_ff @(posedge clk) begin
    if (push) begin
      tag_q[wr_ptr]  <= push_reg;
      data_q[wr_ptr] <= push_data;
    end
  end

  assign head_reg  = tag_q[rd_ptr];
  assign head_data = data_q[rd_ptr];
  assign count     = count_q;

`ifdef VREGFILE_WBQ_BYPASS_EN
  // Walk oldest to youngest so the last match wins; this cycle's push is not yet occupied.
  always_comb begin
    logic [LOG2DEPTH-1:0] idx;
    rd_hit  = 1'b0;
    rd_data = '0;
    idx     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + LOG2DEPTH'(i);
      if (((LOG2DEPTH+1)'(i) < count_q) && (tag_q[idx] == rd_reg)) begin
        rd_hit  = 1'b1;
        rd_data = data_q[idx];
      end
    end
  end
`endif

endmodule

// File: rtl/vregfile_wbqueue.sv
// Write-back queue in front of the vector register file write port: round-robin between
// ALU (p0) and memory (p1) producers, in-order drain. VREGFILE_WBQ_BYPASS_EN adds rd_reg/rd_hit/rd_data.
module vregfile_wbqueue
  import vregfile_wbqueue_pkg::*;
#(
  parameter int WIDTH       = WBQ_WIDTH,
  parameter int NUMREGS     = WBQ_NUMREGS,
  parameter int LOG2NUMREGS = WBQ_LOG2NUMREGS,
  parameter int DEPTH       = WBQ_DEPTH,
  parameter int LOG2DEPTH   = WBQ_LOG2DEPTH
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   p0_valid,
  input  logic [LOG2NUMREGS-1:0] p0_reg,
  input  logic [WIDTH-1:0]       p0_data,
  output logic                   p0_ready,
  input  logic                   p1_valid,
  input  logic [LOG2NUMREGS-1:0] p1_reg,
  input  logic [WIDTH-1:0]       p1_data,
  output logic                   p1_ready,
  input  logic                   wr_stall,
  output logic [LOG2NUMREGS-1:0] c_reg,
  output logic [WIDTH-1:0]       c_writedatain,
  output logic                   c_we,
`ifdef VREGFILE_WBQ_BYPASS_EN
  input  logic [LOG2NUMREGS-1:0] rd_reg,
  output logic                   rd_hit,
  output logic [WIDTH-1:0]       rd_data,
`endif
  output logic [LOG2DEPTH:0]     count
);

  logic                   last_grant;
  logic                   grant_p0, grant_p1;
  logic                   pop, space, push;
  logic [LOG2NUMREGS-1:0] push_reg;
  logic [WIDTH-1:0]       push_data;

  assign pop   = resetn && (count != '0) && !wr_stall;
  assign space = (count < (LOG2DEPTH+1)'(DEPTH)) || pop;

  // On a tie the producer that did not win last time is served, so neither starves.
  assign grant_p0 = p0_valid && (!p1_valid || (last_grant == WBQ_P1));
  assign grant_p1 = p1_valid && (!p0_valid || (last_grant == WBQ_P0));

  assign p0_ready = resetn && space && grant_p0;
  assign p1_ready = resetn && space && grant_p1;

  assign push      = (p0_valid && p0_ready) || (p1_valid && p1_ready);
  assign push_reg  = p1_ready ? p1_reg  : p0_reg;
  assign push_data = p1_ready ? p1_data : p0_data;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                    last_grant <= WBQ_P1;
    else if (p0_valid && p0_ready)  last_grant <= WBQ_P0;
    else if (p1_valid && p1_ready)  last_grant <= WBQ_P1;
  end

  vregfile_wbq_fifo #(
    .WIDTH      (WIDTH),
    .LOG2NUMREGS(LOG2NUMREGS),
    .DEPTH      (DEPTH),
    .LOG2DEPTH  (LOG2DEPTH)
  ) u_fifo (
    .clk      (clk),
    .resetn   (resetn),
    .push     (push),
    .push_reg (push_reg),
    .push_data(push_data),
    .pop      (pop),
    .head_reg (c_reg),
    .head_data(c_writedatain),
`ifdef VREGFILE_WBQ_BYPASS_EN
    .rd_reg   (rd_reg),
    .rd_hit   (rd_hit),
    .rd_data  (rd_data),
`endif
    .count    (count)
  );

  assign c_we = pop;

endmodule

// File: tb/tb_vregfile_wbqueue.sv
// Directed self-checking bench for vregfile_wbqueue; bypass checks build with VREGFILE_WBQ_BYPASS_EN.
module tb_vregfile_wbqueue;
  localparam int W = 32, RW = 4, CW = 3;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          p0_valid = 1'b0, p1_valid = 1'b0, wr_stall = 1'b0;
  logic [RW-1:0] p0_reg = '0, p1_reg = '0, c_reg;
  logic [W-1:0]  p0_data = '0, p1_data = '0, c_writedatain;
  logic          p0_ready, p1_ready, c_we;
  logic [CW-1:0] count;
`ifdef VREGFILE_WBQ_BYPASS_EN
  logic [RW-1:0] rd_reg = '0;
  logic          rd_hit;
  logic [W-1:0]  rd_data;
`endif

  int n_cmp = 0, n_err = 0;

  vregfile_wbqueue dut (
    .clk(clk), .resetn(resetn),
    .p0_valid(p0_valid), .p0_reg(p0_reg), .p0_data(p0_data), .p0_ready(p0_ready),
    .p1_valid(p1_valid), .p1_reg(p1_reg), .p1_data(p1_data), .p1_ready(p1_ready),
    .wr_stall(wr_stall), .c_reg(c_reg), .c_writedatain(c_writedatain), .c_we(c_we),
`ifdef VREGFILE_WBQ_BYPASS_EN
    .rd_reg(rd_reg), .rd_hit(rd_hit), .rd_data(rd_data),
`endif
    .count(count)
  );

  always #5 clk = ~clk;

  // Drives happen at posedge+1, checks at posedge+2.
  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    p0_valid = 0; p1_valid = 0; wr_stall = 0;
    resetn = 0; cyc(); resetn = 1; cyc();
  endtask

  task automatic test_reset();
    p0_valid = 1; p0_reg = 4'd1; p0_data = 32'h1;
    #1;
    n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL reset_count got=%0d exp=0", count); end
    n_cmp++; if (c_we !== 1'b0) begin n_err++; $display("FAIL reset_cwe got=%b exp=0", c_we); end
    n_cmp++; if (p0_ready !== 1'b0) begin n_err++; $display("FAIL reset_p0_ready got=%b exp=0", p0_ready); end
    cyc();
    n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL reset_hold_count got=%0d exp=0", count); end
    p0_valid = 0; resetn = 1; cyc();
  endtask

  task automatic test_single();
    p0_valid = 1; p0_reg = 4'd3; p0_data = 32'hA5; #1;
    n_cmp++; if (p0_ready !== 1'b1) begin n_err++; $display("FAIL single_ready got=%b exp=1", p0_ready); end
    n_cmp++; if (c_we !== 1'b0) begin n_err++; $display("FAIL single_cwe_early got=%b exp=0", c_we); end
    cyc(); p0_valid = 0; #1;
    n_cmp++; if (c_we !== 1'b1) begin n_err++; $display("FAIL single_cwe got=%b exp=1", c_we); end
    n_cmp++; if (c_reg !== 4'd3) begin n_err++; $display("FAIL single_creg got=%0d exp=3", c_reg); end
    n_cmp++; if (c_writedatain !== 32'hA5) begin n_err++; $display("FAIL single_data got=%h exp=a5", c_writedatain); end
    cyc(); #1;
    n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL single_count got=%0d exp=0", count); end
    n_cmp++; if (c_we !== 1'b0) begin n_err++; $display("FAIL single_cwe_empty got=%b exp=0", c_we); end
  endtask

  task automatic test_alternate();
    logic [W-1:0]  prev_d;
    logic [RW-1:0] prev_r;
    do_reset();
    prev_d = '0; prev_r = '0;
    p0_valid = 1; p1_valid = 1; p0_reg = 4'd1; p1_reg = 4'd2;
    for (int k = 0; k < 4; k++) begin
      p0_data = 32'h1000 + k; p1_data = 32'h2000 + k; #1;
      n_cmp++; if (p0_ready !== (k % 2 == 0)) begin n_err++; $display("FAIL alt_p0_ready k=%0d got=%b exp=%b", k, p0_ready, k % 2 == 0); end
      n_cmp++; if (p1_ready !== (k % 2 == 1)) begin n_err++; $display("FAIL alt_p1_ready k=%0d got=%b exp=%b", k, p1_ready, k % 2 == 1); end
      if (k > 0) begin
        n_cmp++; if (c_we !== 1'b1 || c_writedatain !== prev_d || c_reg !== prev_r) begin
          n_err++; $display("FAIL alt_drain k=%0d got we=%b r=%0d d=%h exp we=1 r=%0d d=%h", k, c_we, c_reg, c_writedatain, prev_r, prev_d);
        end
      end
      prev_d = (k % 2 == 0) ? 32'h1000 + k : 32'h2000 + k;
      prev_r = (k % 2 == 0) ? 4'd1 : 4'd2;
      cyc();
    end
    p0_valid = 0; p1_valid = 0; #1;
    n_cmp++; if (c_we !== 1'b1 || c_writedatain !== 32'h2003 || c_reg !== 4'd2) begin
      n_err++; $display("FAIL alt_last got we=%b r=%0d d=%h exp we=1 r=2 d=2003", c_we, c_reg, c_writedatain);
    end
    cyc(); #1;
    n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL alt_count got=%0d exp=0", count); end
  endtask

  task automatic test_full_stall();
    do_reset();
    wr_stall = 1; p0_valid = 1;
    for (int k = 0; k < 4; k++) begin
      p0_reg = RW'(k); p0_data = 32'h30 + k; #1;
      n_cmp++; if (p0_ready !== 1'b1 || c_we !== 1'b0) begin n_err++; $display("FAIL fill k=%0d got rdy=%b we=%b exp rdy=1 we=0", k, p0_ready, c_we); end
      cyc();
    end
    p0_reg = 4'd4; p0_data = 32'h34; #1;
    n_cmp++; if (count !== 3'd4) begin n_err++; $display("FAIL full_count got=%0d exp=4", count); end
    n_cmp++; if (p0_ready !== 1'b0) begin n_err++; $display("FAIL full_ready got=%b exp=0", p0_ready); end
    cyc(); wr_stall = 0; #1;
    n_cmp++; if (p0_ready !== 1'b1 || c_we !== 1'b1 || c_writedatain !== 32'h30 || c_reg !== 4'd0) begin
      n_err++; $display("FAIL full_pushpop got rdy=%b we=%b r=%0d d=%h exp rdy=1 we=1 r=0 d=30", p0_ready, c_we, c_reg, c_writedatain);
    end
    cyc(); p0_valid = 0; #1;
    for (int j = 1; j <= 4; j++) begin
      n_cmp++; if (count !== CW'(5 - j) || c_we !== 1'b1 || c_writedatain !== 32'h30 + j || c_reg !== RW'(j)) begin
        n_err++; $display("FAIL drain j=%0d got cnt=%0d we=%b r=%0d d=%h exp cnt=%0d we=1 r=%0d d=%h", j, count, c_we, c_reg, c_writedatain, 5 - j, j, 32'h30 + j);
      end
      cyc(); #1;
    end
    n_cmp++; if (count !== 3'd0 || c_we !== 1'b0) begin n_err++; $display("FAIL drain_empty got cnt=%0d we=%b exp cnt=0 we=0", count, c_we); end
  endtask

  task automatic test_same_reg();
    wr_stall = 1;
    p0_valid = 1; p0_reg = 4'd5; p0_data = 32'd1; cyc();
    p0_valid = 0; p1_valid = 1; p1_reg = 4'd5; p1_data = 32'd2; #1;
    n_cmp++; if (p1_ready !== 1'b1) begin n_err++; $display("FAIL same_p1_ready got=%b exp=1", p1_ready); end
    cyc(); p1_valid = 0; wr_stall = 0; #1;
    n_cmp++; if (c_we !== 1'b1 || c_reg !== 4'd5 || c_writedatain !== 32'd1) begin n_err++; $display("FAIL same_first got we=%b r=%0d d=%h exp we=1 r=5 d=1", c_we, c_reg, c_writedatain); end
    cyc(); #1;
    n_cmp++; if (c_we !== 1'b1 || c_reg !== 4'd5 || c_writedatain !== 32'd2) begin n_err++; $display("FAIL same_second got we=%b r=%0d d=%h exp we=1 r=5 d=2", c_we, c_reg, c_writedatain); end
    cyc(); #1;
    n_cmp++; if (count !== 3'd0 || c_we !== 1'b0) begin n_err++; $display("FAIL same_empty got cnt=%0d we=%b exp cnt=0 we=0", count, c_we); end
  endtask

  task automatic test_reset_mid();
    wr_stall = 1; p0_valid = 1;
    for (int k = 0; k < 3; k++) begin p0_reg = 4'd9; p0_data = 32'h90 + k; cyc(); end
    p0_valid = 0; #1;
    n_cmp++; if (count !== 3'd3) begin n_err++; $display("FAIL mid_count got=%0d exp=3", count); end
    wr_stall = 0; #1;
    n_cmp++; if (c_we !== 1'b1) begin n_err++; $display("FAIL mid_cwe got=%b exp=1", c_we); end
    cyc(); resetn = 0; #1;
    n_cmp++; if (count !== 3'd0 || c_we !== 1'b0) begin n_err++; $display("FAIL mid_reset got cnt=%0d we=%b exp cnt=0 we=0", count, c_we); end
    cyc(); resetn = 1;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_cmp++; if (c_we !== 1'b0 || count !== 3'd0) begin n_err++; $display("FAIL mid_stale k=%0d got we=%b cnt=%0d exp we=0 cnt=0", k, c_we, count); end
      cyc();
    end
  endtask

`ifdef VREGFILE_WBQ_BYPASS_EN
  task automatic test_bypass();
    do_reset();
    wr_stall = 1; rd_reg = 4'd7;
    p0_valid = 1; p0_reg = 4'd7; p0_data = 32'h11; #1;
    n_cmp++; if (rd_hit !== 1'b0) begin n_err++; $display("FAIL byp_pushing got=%b exp=0", rd_hit); end
    cyc(); p0_data = 32'h22; #1;
    n_cmp++; if (rd_hit !== 1'b1 || rd_data !== 32'h11) begin n_err++; $display("FAIL byp_first got hit=%b d=%h exp hit=1 d=11", rd_hit, rd_data); end
    cyc(); p0_valid = 0; #1;
    n_cmp++; if (rd_hit !== 1'b1 || rd_data !== 32'h22) begin n_err++; $display("FAIL byp_youngest got hit=%b d=%h exp hit=1 d=22", rd_hit, rd_data); end
    rd_reg = 4'd8; #1;
    n_cmp++; if (rd_hit !== 1'b0) begin n_err++; $display("FAIL byp_miss got=%b exp=0", rd_hit); end
    rd_reg = 4'd7; wr_stall = 0; cyc(); cyc(); #1;
    n_cmp++; if (rd_hit !== 1'b0 || count !== 3'd0) begin n_err++; $display("FAIL byp_drained got hit=%b cnt=%0d exp hit=0 cnt=0", rd_hit, count); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_alternate();
    test_full_stall();
    test_same_reg();
    test_reset_mid();
`ifdef VREGFILE_WBQ_BYPASS_EN
    test_bypass();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
